// File: rtl/xadc_drp_pkg.sv
// Shared types for the XADC DRP to AXI-Stream adapter: DRP result-register
// addresses, the read-sequencer state encoding and the fixed widths.
package xadc_drp_pkg;

  localparam int AXIS_DATA_W = 16;
  localparam int DRP_ADDR_W  = 7;

  // DRP addresses of the auxiliary-channel result registers we read.
  typedef enum logic [DRP_ADDR_W-1:0] {
    XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h14,  // VAUX4
    XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h1C   // VAUX12
  } xadc_drp_addr_t;

  // Read sequencer: voltage first, then current, once per end-of-sequence.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_V,
    ST_WAIT_V,
    ST_REQ_C,
    ST_WAIT_C
  } xadc_drp_state_t;

endpackage

// File: rtl/xadc_drp_axis_adapter_if.sv
// 16-bit AXI-Stream link without side-band signals. Source drives data and
// valid; Sink drives ready.
interface axis_io;
  import xadc_drp_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport Source (output tdata, output tvalid, input tready);
  modport Sink   (input tdata, input tvalid, output tready);

endinterface

// File: rtl/xadc_drp_axis_adapter_axis_sample_reg.sv
// One-entry AXI-Stream output register. A load is accepted when the slot is
// empty or being drained this cycle; otherwise the new sample is dropped so
// the held one stays stable under backpressure.
module axis_sample_reg
  import xadc_drp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [AXIS_DATA_W-1:0] data_in,
  axis_io.Source                 axis
);

  logic [AXIS_DATA_W-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;

  // Next-state: drain on handshake, then overlay an accepted load.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (tvalid_q && axis.tready) tvalid_d = 1'b0;
    if (load && (!tvalid_q || axis.tready)) begin
      tdata_d  = data_in;
      tvalid_d = 1'b1;
    end
  end

  // Slot register; reset discards any pending sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;

endmodule

// File: rtl/xadc_drp_axis_adapter.sv
// On each XADC end-of-sequence, reads the voltage and then the current-monitor
// result registers over DRP and presents each raw 16-bit word on its own
// AXI-Stream output. Only the DRP read path is used.
module xadc_drp_axis_adapter
  import xadc_drp_pkg::*;
(
  input  logic                   xadc_dclk,
  input  logic                   xadc_reset,
  output logic [DRP_ADDR_W-1:0]  xadc_daddr,
  output logic                   xadc_den,
  input  logic                   xadc_drdy,
  input  logic [AXIS_DATA_W-1:0] xadc_do,
  input  logic                   xadc_eos,
  axis_io.Source                 voltage_channel,
  axis_io.Source                 current_monitor_channel
);

  xadc_drp_state_t state_q, state_d;
  xadc_drp_addr_t  daddr_q, daddr_d;
  logic            den_q, den_d;
  logic            load_v, load_c;

  // Sequencer: den/daddr are registered alongside the transition into a
  // request state so they appear exactly during that one-cycle state.
  // daddr only changes when a new request is issued, so it holds otherwise.
  always_comb begin
    state_d = state_q;
    daddr_d = daddr_q;
    den_d   = 1'b0;
    load_v  = 1'b0;
    load_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xadc_eos) begin
          state_d = ST_REQ_V;
          den_d   = 1'b1;
          daddr_d = XADC_DRP_ADDR_VOLTAGE_CHANNEL;
        end
      end
      ST_REQ_V: state_d = ST_WAIT_V;
      ST_WAIT_V: begin
        if (xadc_drdy) begin
          load_v  = 1'b1;
          state_d = ST_REQ_C;
          den_d   = 1'b1;
          daddr_d = XADC_DRP_ADDR_CURRENT_CHANNEL;
        end
      end
      ST_REQ_C: state_d = ST_WAIT_C;
      ST_WAIT_C: begin
        if (xadc_drdy) begin
          load_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and DRP request registers.
  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      state_q <= ST_IDLE;
      daddr_q <= XADC_DRP_ADDR_VOLTAGE_CHANNEL;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      daddr_q <= daddr_d;
      den_q   <= den_d;
    end
  end

  assign xadc_den   = den_q;
  assign xadc_daddr = daddr_q;

  axis_sample_reg u_voltage_reg (
    .clk     (xadc_dclk),
    .rst     (xadc_reset),
    .load    (load_v),
    .data_in (xadc_do),
    .axis    (voltage_channel)
  );

  axis_sample_reg u_current_reg (
    .clk     (xadc_dclk),
    .rst     (xadc_reset),
    .load    (load_c),
    .data_in (xadc_do),
    .axis    (current_monitor_channel)
  );

endmodule

// File: tb/tb_xadc_drp_axis_adapter.sv
// Bench for xadc_drp_axis_adapter: a DRP responder model, a negedge monitor
// logging DRP requests and stream handshakes, and one task per scenario.
module tb_xadc_drp_axis_adapter;
  import xadc_drp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eos = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] drp_do = '0;
  logic [6:0]  daddr;
  logic        den;

  axis_io v_if ();
  axis_io c_if ();

  int n_cmp  = 0;
  int n_fail = 0;

  initial forever #5 clk = ~clk;

  xadc_drp_axis_adapter dut (
    .xadc_dclk               (clk),
    .xadc_reset              (rst),
    .xadc_daddr              (daddr),
    .xadc_den                (den),
    .xadc_drdy               (drdy),
    .xadc_do                 (drp_do),
    .xadc_eos                (eos),
    .voltage_channel         (v_if),
    .current_monitor_channel (c_if)
  );

  // DRP responder: answers each den after a latency with either fixed or
  // random data and records what it returned per channel.
  int          lat_min = 1, lat_max = 1;
  bit          bfm_rand = 0;
  logic [15:0] fix_v = '0, fix_c = '0;
  int          n_ret = 0;
  logic [15:0] ret_v[$], ret_c[$];

  initial begin : bfm
    logic [6:0]  a;
    logic [15:0] val;
    int          lat;
    forever begin
      @(negedge clk);
      if (den && !rst) begin
        a   = daddr;
        lat = $urandom_range(lat_max, lat_min);
        if (bfm_rand) val = 16'($urandom);
        else          val = (a == 7'h1C) ? fix_v : fix_c;
        repeat (lat) @(posedge clk);
        #1;
        drdy = 1'b1;
        drp_do = val;
        if (a == 7'h1C) ret_v.push_back(val);
        else            ret_c.push_back(val);
        n_ret++;
        @(posedge clk);
        #1 drdy = 1'b0;
      end
    end
  end

  // Monitor: DRP requests, stream handshakes, den while a read is pending.
  logic [6:0]  den_q[$];
  logic [15:0] hs_v[$], hs_c[$];
  int          den_viol = 0;
  bit          outst = 0;

  always @(negedge clk) begin
    if (drdy) outst = 0;
    if (den) begin
      if (outst) den_viol++;
      outst = 1;
      den_q.push_back(daddr);
    end
    if (!rst && v_if.tvalid && v_if.tready) hs_v.push_back(v_if.tdata);
    if (!rst && c_if.tvalid && c_if.tready) hs_c.push_back(c_if.tdata);
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    den_q.delete(); hs_v.delete(); hs_c.delete();
    ret_v.delete(); ret_c.delete();
  endtask

  task automatic pulse_eos();
    @(posedge clk); #1 eos = 1'b1;
    @(posedge clk); #1 eos = 1'b0;
  endtask

  // Pulses eos and waits for both reads to return, plus settle time.
  task automatic run_seq(output bit ok);
    int start;
    start = n_ret;
    pulse_eos();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_ret >= start + 2) begin ok = 1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v_if.tready = 1'b1;
    c_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (den !== 1'b0) begin n_fail++; $display("FAIL reset_den: got %b exp 0", den); end
    n_cmp++; if (daddr !== 7'h1C) begin n_fail++; $display("FAIL reset_daddr: got %h exp 1c", daddr); end
    n_cmp++; if (v_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_v_tvalid: got %b exp 0", v_if.tvalid); end
    n_cmp++; if (c_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_c_tvalid: got %b exp 0", c_if.tvalid); end
    n_cmp++; if (v_if.tdata !== 16'h0) begin n_fail++; $display("FAIL reset_v_tdata: got %h exp 0000", v_if.tdata); end
    n_cmp++; if (c_if.tdata !== 16'h0) begin n_fail++; $display("FAIL reset_c_tdata: got %h exp 0000", c_if.tdata); end
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    n_cmp++; if (den_q.size() != 0) begin n_fail++; $display("FAIL idle_no_drp: got %0d requests exp 0", den_q.size()); end
  endtask

  task automatic test_single();
    bit found;
    lat_min = 2; lat_max = 2; bfm_rand = 0;
    fix_v = 16'hA5A0; fix_c = 16'h3C30;
    clear_logs();
    @(posedge clk); #1 eos = 1'b1;
    @(negedge clk);
    n_cmp++; if (den !== 1'b0) begin n_fail++; $display("FAIL den_before_eos_edge: got %b exp 0", den); end
    @(posedge clk); #1 eos = 1'b0;
    @(negedge clk);
    n_cmp++; if (den !== 1'b1 || daddr !== 7'h1C) begin n_fail++; $display("FAIL den_after_eos: got den=%b addr=%h exp den=1 addr=1c", den, daddr); end
    // voltage result: valid exactly one cycle after drdy, current request alongside
    found = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (drdy) begin found = 1; break; end end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL v_drdy_timeout: got none exp drdy"); end
    n_cmp++; if (v_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL v_valid_early: got %b exp 0", v_if.tvalid); end
    @(negedge clk);
    n_cmp++; if (v_if.tvalid !== 1'b1 || v_if.tdata !== 16'hA5A0) begin n_fail++; $display("FAIL v_capture: got v=%b d=%h exp v=1 d=a5a0", v_if.tvalid, v_if.tdata); end
    n_cmp++; if (den !== 1'b1 || daddr !== 7'h14) begin n_fail++; $display("FAIL c_request: got den=%b addr=%h exp den=1 addr=14", den, daddr); end
    found = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (drdy) begin found = 1; break; end end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL c_drdy_timeout: got none exp drdy"); end
    n_cmp++; if (c_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL c_valid_early: got %b exp 0", c_if.tvalid); end
    @(negedge clk);
    n_cmp++; if (c_if.tvalid !== 1'b1 || c_if.tdata !== 16'h3C30) begin n_fail++; $display("FAIL c_capture: got v=%b d=%h exp v=1 d=3c30", c_if.tvalid, c_if.tdata); end
    repeat (5) @(negedge clk);
    n_cmp++; if (den_q.size() != 2) begin n_fail++; $display("FAIL single_den_count: got %0d exp 2", den_q.size()); end
    else begin
      n_cmp++; if (den_q[0] !== 7'h1C || den_q[1] !== 7'h14) begin n_fail++; $display("FAIL single_den_order: got %h,%h exp 1c,14", den_q[0], den_q[1]); end
    end
    n_cmp++; if (hs_v.size() != 1 || hs_c.size() != 1) begin n_fail++; $display("FAIL single_hs_count: got %0d,%0d exp 1,1", hs_v.size(), hs_c.size()); end
    else begin
      n_cmp++; if (hs_v[0] !== 16'hA5A0 || hs_c[0] !== 16'h3C30) begin n_fail++; $display("FAIL single_hs_data: got %h,%h exp a5a0,3c30", hs_v[0], hs_c[0]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    lat_min = 1; lat_max = 3; bfm_rand = 0;
    clear_logs();
    v_if.tready = 1'b0;
    fix_v = 16'h1110; fix_c = 16'($urandom);
    run_seq(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_seq1_timeout: got none exp 2 reads"); end
    fix_v = 16'h2220;
    run_seq(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_seq2_timeout: got none exp 2 reads"); end
    n_cmp++; if (v_if.tvalid !== 1'b1 || v_if.tdata !== 16'h1110) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h exp v=1 d=1110", v_if.tvalid, v_if.tdata); end
    n_cmp++; if (hs_v.size() != 0) begin n_fail++; $display("FAIL bp_no_hs: got %0d exp 0", hs_v.size()); end
    n_cmp++; if (hs_c.size() != 2) begin n_fail++; $display("FAIL bp_current_flow: got %0d exp 2", hs_c.size()); end
    @(posedge clk); #1 v_if.tready = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (hs_v.size() != 1) begin n_fail++; $display("FAIL bp_release_count: got %0d exp 1", hs_v.size()); end
    else begin
      n_cmp++; if (hs_v[0] !== 16'h1110) begin n_fail++; $display("FAIL bp_release_data: got %h exp 1110", hs_v[0]); end
    end
    n_cmp++; if (v_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b exp 0", v_if.tvalid); end
  endtask

  task automatic test_eos_during();
    bit found;
    int start;
    lat_min = 4; lat_max = 4; bfm_rand = 1;
    clear_logs();
    start = n_ret;
    pulse_eos();
    found = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (den_q.size() == 1) begin found = 1; break; end end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL eos_mid_req_timeout: got %0d exp 1", den_q.size()); end
    pulse_eos();  // lands while waiting for the voltage read
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (n_ret >= start + 2) break; end
    repeat (15) @(negedge clk);
    n_cmp++; if (den_q.size() != 2) begin n_fail++; $display("FAIL eos_mid_no_restart: got %0d requests exp 2", den_q.size()); end
    n_cmp++; if (hs_v.size() != 1 || hs_c.size() != 1) begin n_fail++; $display("FAIL eos_mid_samples: got %0d,%0d exp 1,1", hs_v.size(), hs_c.size()); end
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    lat_min = 6; lat_max = 6; bfm_rand = 1;
    clear_logs();
    v_if.tready = 1'b0;
    pulse_eos();
    found = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (den_q.size() == 2) begin found = 1; break; end end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rmid_reach_wait_c: got %0d requests exp 2", den_q.size()); end
    n_cmp++; if (v_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_v_pending: got %b exp 1", v_if.tvalid); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (den !== 1'b0 || daddr !== 7'h1C) begin n_fail++; $display("FAIL rmid_drp: got den=%b addr=%h exp den=0 addr=1c", den, daddr); end
    n_cmp++; if (v_if.tvalid !== 1'b0 || v_if.tdata !== 16'h0) begin n_fail++; $display("FAIL rmid_v: got v=%b d=%h exp v=0 d=0000", v_if.tvalid, v_if.tdata); end
    n_cmp++; if (c_if.tvalid !== 1'b0 || c_if.tdata !== 16'h0) begin n_fail++; $display("FAIL rmid_c: got v=%b d=%h exp v=0 d=0000", c_if.tvalid, c_if.tdata); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(negedge clk);  // late drdy lands in IDLE and is ignored
    n_cmp++; if (c_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_drdy: got %b exp 0", c_if.tvalid); end
    v_if.tready = 1'b1;
    lat_min = 1; lat_max = 3; bfm_rand = 0;
    fix_v = 16'($urandom); fix_c = 16'($urandom);
    clear_logs();
    run_seq(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_clean_timeout: got none exp 2 reads"); end
    n_cmp++; if (den_q.size() != 2) begin n_fail++; $display("FAIL rmid_clean_den: got %0d exp 2", den_q.size()); end
    n_cmp++; if (hs_v.size() != 1 || hs_c.size() != 1) begin n_fail++; $display("FAIL rmid_clean_count: got %0d,%0d exp 1,1", hs_v.size(), hs_c.size()); end
    else begin
      n_cmp++; if (hs_v[0] !== fix_v || hs_c[0] !== fix_c) begin n_fail++; $display("FAIL rmid_clean_data: got %h,%h exp %h,%h", hs_v[0], hs_c[0], fix_v, fix_c); end
    end
  endtask

  task automatic test_continuous();
    bit ok;
    int timeouts;
    lat_min = 1; lat_max = 4; bfm_rand = 1;
    v_if.tready = 1'b1; c_if.tready = 1'b1;
    clear_logs();
    timeouts = 0;
    for (int s = 0; s < 10; s++) begin
      run_seq(ok);
      if (!ok) timeouts++;
      repeat ($urandom_range(5, 0)) @(negedge clk);
    end
    n_cmp++; if (timeouts != 0) begin n_fail++; $display("FAIL cont_timeouts: got %0d exp 0", timeouts); end
    n_cmp++; if (hs_v.size() != 10 || ret_v.size() != 10) begin n_fail++; $display("FAIL cont_v_count: got %0d exp 10 (returned %0d)", hs_v.size(), ret_v.size()); end
    else for (int i = 0; i < 10; i++) begin
      n_cmp++; if (hs_v[i] !== ret_v[i]) begin n_fail++; $display("FAIL cont_v_data[%0d]: got %h exp %h", i, hs_v[i], ret_v[i]); end
    end
    n_cmp++; if (hs_c.size() != 10 || ret_c.size() != 10) begin n_fail++; $display("FAIL cont_c_count: got %0d exp 10 (returned %0d)", hs_c.size(), ret_c.size()); end
    else for (int i = 0; i < 10; i++) begin
      n_cmp++; if (hs_c[i] !== ret_c[i]) begin n_fail++; $display("FAIL cont_c_data[%0d]: got %h exp %h", i, hs_c[i], ret_c[i]); end
    end
    n_cmp++; if (den_q.size() != 20) begin n_fail++; $display("FAIL cont_den_count: got %0d exp 20", den_q.size()); end
    n_cmp++; if (den_viol != 0) begin n_fail++; $display("FAIL den_while_outstanding: got %0d exp 0", den_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_eos_during();
    test_reset_mid();
    test_continuous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
